// File: rtl/uart_char_rx.sv
// uart_char_rx: asynchronous serial character receiver (8N1, optionally 8E1).
// Deserialises rxd into bytes. Good bytes appear on char_out with a one-cycle
// char_valid strobe. Stop-bit or parity faults give a one-cycle frame_err
// strobe and leave char_out untouched.
// Optional feature: define UART_RX_PARITY_EN for an even-parity bit between
// the data and stop bits.
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   rxd        serial line, idles high, asynchronous to clk
//   char_out   last good received byte (LSB first on the line)
//   char_valid one-cycle pulse, char_out is new in that cycle
//   frame_err  one-cycle pulse on bad stop bit (or bad parity)
//   busy       high whenever the receiver is not idle
module uart_char_rx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] char_out,
    output logic       char_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TICK_MID = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_BREAK
    } state_e;

    logic          rxd_meta_q;
    logic          rs_q;
    state_e        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    char_out_q, char_out_d;
    logic          char_valid_q, char_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    // Synchroniser, counters, shift register and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxd_meta_q   <= 1'b1;
            rs_q         <= 1'b1;
            state_q      <= ST_IDLE;
            tick_q       <= '0;
            bit_idx_q    <= '0;
            shreg_q      <= '0;
            char_out_q   <= '0;
            char_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            rxd_meta_q   <= rxd;
            rs_q         <= rxd_meta_q;
            state_q      <= state_d;
            tick_q       <= tick_d;
            bit_idx_q    <= bit_idx_d;
            shreg_q      <= shreg_d;
            char_out_q   <= char_out_d;
            char_valid_q <= char_valid_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
`ifdef UART_RX_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d      = state_q;
        tick_d       = (tick_q == TICK_END) ? '0 : tick_q + TW'(1);
        bit_idx_d    = bit_idx_q;
        shreg_d      = shreg_q;
        char_out_d   = char_out_q;
        char_valid_d = 1'b0;
        frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_d     = parity_q;
`endif

        case (state_q)
            ST_IDLE: begin
                tick_d = '0;
                if (!rs_q) begin
                    state_d = ST_START;
                end
            end
            // Re-check the line mid start bit to reject glitches.
            ST_START: begin
                if (tick_q == TICK_MID) begin
                    tick_d    = '0;
                    bit_idx_d = '0;
                    state_d   = rs_q ? ST_IDLE : ST_DATA;
                end
            end
            // Shift right so the first bit on the line ends up in bit 0.
            ST_DATA: begin
                if (tick_q == TICK_END) begin
                    shreg_d   = {rs_q, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'(1);
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick_q == TICK_END) begin
                    parity_d = rs_q;
                    state_d  = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick_q == TICK_END) begin
                    if (!rs_q) begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end else begin
                        state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (^{shreg_q, parity_q}) begin
                            frame_err_d = 1'b1;
                        end else begin
                            char_out_d   = shreg_q;
                            char_valid_d = 1'b1;
                        end
`else
                        char_out_d   = shreg_q;
                        char_valid_d = 1'b1;
`endif
                    end
                end
            end
            // Line held low after a bad stop: wait for it to release.
            ST_BREAK: begin
                tick_d = '0;
                if (rs_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign char_out   = char_out_q;
    assign char_valid = char_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule
